// File: rtl/wb_gpio_btn_led_pkg.sv
// Shared constants for the Wishbone button/LED GPIO block: register map,
// parameter defaults, debounce limit reset value and byte-lane helpers.
package wb_gpio_btn_led_pkg;

  localparam int          N_BTN_DEF     = 3;
  localparam int          N_LED_DEF     = 8;
  localparam int          DEB_W_DEF     = 16;
  localparam int          PWM_W_DEF     = 8;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;

  localparam int unsigned DEB_LIM_RST   = 1000;

  localparam logic [2:0] REG_LED_OUT   = 3'd0;
  localparam logic [2:0] REG_LED_OEB   = 3'd1;
  localparam logic [2:0] REG_LED_MODE  = 3'd2;
  localparam logic [2:0] REG_PWM_DUTY  = 3'd3;
  localparam logic [2:0] REG_BTN_STATE = 3'd4;
  localparam logic [2:0] REG_IRQ_EN    = 3'd5;
  localparam logic [2:0] REG_IRQ_PEND  = 3'd6;
  localparam logic [2:0] REG_DEB_LIM   = 3'd7;

  // Expand a 4-bit byte select into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Replace only the selected byte lanes of cur with wdat.
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    return (cur & ~byte_mask(sel)) | (wdat & byte_mask(sel));
  endfunction

endpackage

// File: rtl/wb_gpio_btn_led_btn_debounce.sv
// One button channel: two-flop synchroniser followed by a counting debouncer.
// rise is asserted in the cycle whose closing edge makes stable go 0 -> 1,
// so anything latching on rise updates on the same edge as stable.
module btn_debounce
  import wb_gpio_btn_led_pkg::*;
#(
  parameter int DEB_W = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [DEB_W-1:0] deb_lim,
  output logic             stable,
  output logic             rise
);

  logic             sync_1;
  logic             sync_2;
  logic [DEB_W-1:0] cnt;
  logic             at_lim;

  // >= rather than == keeps the counter bounded if the limit is lowered mid-count
  assign at_lim = (cnt >= deb_lim);
  assign rise   = sync_2 & ~stable & at_lim;

  // Bring the asynchronous button level into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive mismatch cycles; accept the new level once the limit is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_2 == stable) begin
      cnt <= '0;
    end else if (at_lim) begin
      cnt    <= '0;
      stable <= sync_2;
    end else begin
      cnt <= cnt + DEB_W'(1);
    end
  end

endmodule

// File: rtl/wb_gpio_btn_led.sv
// Wishbone classic slave with debounced buttons, interrupt-on-press and
// LED outputs that can be driven statically or through a shared PWM.
module wb_gpio_btn_led
  import wb_gpio_btn_led_pkg::*;
#(
  parameter int          N_BTN     = N_BTN_DEF,
  parameter int          N_LED     = N_LED_DEF,
  parameter int          DEB_W     = DEB_W_DEF,
  parameter int          PWM_W     = PWM_W_DEF,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [N_BTN-1:0] buttons,
  output logic [N_LED-1:0] leds,
  output logic [N_LED-1:0] led_enb,
  output logic             irq
);

  localparam logic [DEB_W-1:0] DEB_LIM_INIT = DEB_W'(DEB_LIM_RST);

  logic             sel_hit;
  logic             wr_en;
  logic             ack;
  logic [2:0]       reg_idx;
  logic [31:0]      rd_val;
  logic [31:0]      wr_merged;
  logic [31:0]      w1c_mask;
  logic [N_LED-1:0] led_out;
  logic [N_LED-1:0] led_oeb;
  logic [N_LED-1:0] led_mode;
  logic [PWM_W-1:0] pwm_duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;
  logic [N_BTN-1:0] irq_en;
  logic [N_BTN-1:0] irq_pend;
  logic [N_BTN-1:0] pend_clr;
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_rise;
  logic [DEB_W-1:0] deb_lim;
  logic             unused_bits;

  assign sel_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign reg_idx   = wbs_adr_i[4:2];
  // Commit happens in the cycle ack is high, so an aborted cycle never writes
  assign wr_en     = sel_hit & wbs_we_i & ack;
  assign wbs_ack_o = ack;

  // Partial-lane writes keep the untouched lanes of the current register value
  assign wr_merged = lane_merge(rd_val, wbs_dat_i, wbs_sel_i);
  assign w1c_mask  = wbs_dat_i & byte_mask(wbs_sel_i);
  assign pend_clr  = (wr_en && reg_idx == REG_IRQ_PEND) ? w1c_mask[N_BTN-1:0] : '0;
  assign pwm_on    = (pwm_cnt < pwm_duty);

  assign unused_bits = ^{wbs_adr_i[1:0], wr_merged, w1c_mask};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .btn     (buttons[i]),
      .deb_lim (deb_lim),
      .stable  (btn_stable[i]),
      .rise    (btn_rise[i])
    );
  end

  // Read mux over the full 8-entry window, zero-extended
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_LED_OUT:   rd_val = 32'(led_out);
      REG_LED_OEB:   rd_val = 32'(led_oeb);
      REG_LED_MODE:  rd_val = 32'(led_mode);
      REG_PWM_DUTY:  rd_val = 32'(pwm_duty);
      REG_BTN_STATE: rd_val = 32'(btn_stable);
      REG_IRQ_EN:    rd_val = 32'(irq_en);
      REG_IRQ_PEND:  rd_val = 32'(irq_pend);
      REG_DEB_LIM:   rd_val = 32'(deb_lim);
      default:       rd_val = '0;
    endcase
  end

  // Bus response: one-cycle ack pulse with read data captured alongside it
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack       <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      ack       <= sel_hit & ~ack;
      wbs_dat_o <= (sel_hit & ~ack) ? rd_val : '0;
    end
  end

  // Configuration registers written on the ack cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      led_out  <= '0;
      led_oeb  <= '1;
      led_mode <= '0;
      pwm_duty <= '0;
      irq_en   <= '0;
      deb_lim  <= DEB_LIM_INIT;
    end else if (wr_en) begin
      case (reg_idx)
        REG_LED_OUT:  led_out  <= wr_merged[N_LED-1:0];
        REG_LED_OEB:  led_oeb  <= wr_merged[N_LED-1:0];
        REG_LED_MODE: led_mode <= wr_merged[N_LED-1:0];
        REG_PWM_DUTY: pwm_duty <= wr_merged[PWM_W-1:0];
        REG_IRQ_EN:   irq_en   <= wr_merged[N_BTN-1:0];
        REG_DEB_LIM:  deb_lim  <= wr_merged[DEB_W-1:0];
        default:      ;
      endcase
    end
  end

  // Pending bits latch on press regardless of enable; a new press beats a clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_pend <= '0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= (irq_pend & ~pend_clr) | btn_rise;
      irq      <= |(irq_pend & irq_en);
    end
  end

  // Free-running PWM and registered LED / output-enable drive
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pwm_cnt <= '0;
      leds    <= '0;
      led_enb <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      leds    <= led_out & (~led_mode | {N_LED{pwm_on}});
      led_enb <= led_oeb;
    end
  end

endmodule

// File: tb/tb_wb_gpio_btn_led.sv
// Directed + randomized bench for wb_gpio_btn_led with a register-level model.
module tb_wb_gpio_btn_led;
  import wb_gpio_btn_led_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat_o;
  logic [2:0]  buttons = 3'b000;
  logic [7:0]  leds;
  logic [7:0]  led_enb;
  logic        irq;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned edge_cnt = 0;
  int unsigned last_ack_edge = 0;
  logic [31:0] m [8];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  wb_gpio_btn_led dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat_o),
    .buttons   (buttons),
    .leds      (leds),
    .led_enb   (led_enb),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] reg_mask(input int idx);
    case (idx)
      0, 1, 2, 3: return 32'h0000_00FF;
      5, 6:       return 32'h0000_0007;
      7:          return 32'h0000_FFFF;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{s[b]}};
    return r;
  endfunction

  task automatic model_reset();
    m[0] = 32'h0;  m[1] = 32'hFF; m[2] = 32'h0; m[3] = 32'h0;
    m[4] = 32'h0;  m[5] = 32'h0;  m[6] = 32'h0; m[7] = 32'd1000;
  endtask

  task automatic model_wr(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm;
    bm = lanes(s);
    if (idx == 6)      m[6] = m[6] & ~(d & bm & reg_mask(6));
    else if (idx != 4) m[idx] = ((m[idx] & ~bm) | (d & bm)) & reg_mask(idx);
  endtask

  // Classic cycle: strobe held until the edge that samples ack, then released.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output logic acked);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    acked = 1'b0; rd = 32'h0; n = 0;
    while (!acked && n < 20) begin
      @(posedge clk); #1; n++;
      if (ack === 1'b1) begin
        acked = 1'b1;
        rd = rdat_o;
        last_ack_edge = edge_cnt;
      end
    end
    if (acked) begin @(posedge clk); #1; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic        a;
    wb_xfer(1'b1, BASE | (32'(idx) << 2), s, d, r, a);
    check($sformatf("wr_ack%0d", idx), 32'(a), 32'h1);
    model_wr(idx, d, s);
  endtask

  task automatic rd_raw(input int idx, output logic [31:0] r);
    logic a;
    wb_xfer(1'b0, BASE | (32'(idx) << 2), 4'hF, 32'h0, r, a);
    check($sformatf("rd_ack%0d", idx), 32'(a), 32'h1);
  endtask

  task automatic rd_chk(input int idx, input string tag);
    logic [31:0] r;
    rd_raw(idx, r);
    check($sformatf("%s_reg%0d", tag, idx), r, m[idx]);
  endtask

  task automatic count_high(output int c);
    c = 0;
    tick(1);
    for (int k = 0; k < 256; k++) begin
      tick(1);
      c += int'(leds[0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        a;
    int          c;
    int unsigned e0;
    int          idx;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] duties [3];

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat_o, 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_led_enb", 32'(led_enb), 32'hFF);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) rd_chk(i, "rst");

    // LED output path and readback
    wr(0, 32'h1234_56A5, 4'b0001);
    check("leds_not_yet", 32'(leds), 32'h0);
    wr(1, 32'h0, 4'hF);
    tick(1);
    check("leds_a5", 32'(leds), m[0]);
    check("led_enb_0", 32'(led_enb), m[1]);
    rd_chk(0, "led_out");

    // Held strobe: ack on every second edge
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; c = 0;
    repeat (6) begin @(posedge clk); #1; if (ack === 1'b1) c++; end
    cyc = 1'b0; stb = 1'b0;
    check("ack_every_2nd", 32'(c), 32'd3);
    tick(1);
    check("dat_idle_zero", rdat_o, 32'h0);

    // Debounce with limit 4: new level visible 2 + 5 edges after input settles
    wr(7, 32'd4, 4'hF);
    buttons = 3'b001; tick(1);
    buttons = 3'b000; tick(1);
    buttons = 3'b001; e0 = edge_cnt;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      rd_raw(4, r);
      check("deb_press", r, (last_ack_edge >= e0 + 8) ? 32'h1 : 32'h0);
    end
    m[4] = 32'h1;
    m[6] = m[6] | 32'h1;
    rd_chk(6, "pend_disabled");
    tick(1);
    check("irq_masked", 32'(irq), 32'h0);

    buttons = 3'b000; e0 = edge_cnt;
    for (int k = 0; k < 8; k++) begin
      rd_raw(4, r);
      check("deb_release", r, (last_ack_edge >= e0 + 8) ? 32'h0 : 32'h1);
    end
    m[4] = 32'h0;

    // Interrupt set / clear / set-wins-over-clear
    wr(7, 32'd0, 4'hF);
    wr(5, 32'd1, 4'hF);
    wr(6, 32'd1, 4'hF);
    tick(1);
    check("irq_cleared0", 32'(irq), 32'h0);
    buttons = 3'b001; tick(6);
    m[4] = 32'h1; m[6] = m[6] | 32'h1;
    rd_chk(6, "pend_rise");
    check("irq_on", 32'(irq), 32'h1);
    wr(6, 32'd1, 4'hF);
    tick(1);
    check("irq_w1c", 32'(irq), 32'h0);
    rd_chk(6, "pend_w1c");
    buttons = 3'b000; tick(6);
    m[4] = 32'h0;
    buttons = 3'b001; tick(1);
    wr(6, 32'd1, 4'hF);
    m[4] = 32'h1; m[6] = m[6] | 32'h1;
    rd_chk(6, "pend_set_wins");
    tick(1);
    check("irq_set_wins", 32'(irq), 32'h1);

    // PWM duty on LED0
    wr(2, 32'h01, 4'hF);
    wr(0, 32'h01, 4'hF);
    wr(3, 32'd64, 4'hF);
    count_high(c);
    check("pwm_duty64", 32'(c), 32'd64);
    duties[0] = 32'd0;
    duties[1] = 32'd255;
    duties[2] = 32'($urandom_range(1, 254));
    for (int k = 0; k < 3; k++) begin
      wr(3, duties[k], 4'hF);
      count_high(c);
      check($sformatf("pwm_duty%0d", duties[k]), 32'(c), duties[k]);
    end

    // Randomized register traffic against the model
    buttons = 3'($urandom_range(0, 7));
    tick(6);
    m[4] = 32'(buttons);
    wr(6, 32'h7, 4'hF);
    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(0, 7));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) wr(idx, d, s);
      else rd_chk(idx, "rand_rd");
    end
    for (int i = 0; i < 8; i++) rd_chk(i, "rand_sweep");
    tick(1);
    check("rand_leds_static", 32'(leds & ~m[2][7:0]), m[0] & ~m[2]);
    check("rand_led_enb", 32'(led_enb), m[1]);
    check("rand_irq", 32'(irq), 32'(|(m[5] & m[6])));

    // Addresses just outside the window get no ack
    wb_xfer(1'b0, BASE + 32'h20, 4'hF, 32'h0, r, a);
    check("offwin_hi", 32'(a), 32'h0);
    wb_xfer(1'b0, BASE - 32'h4, 4'hF, 32'h0, r, a);
    check("offwin_lo", 32'(a), 32'h0);

    // Reset between request and ack aborts the write
    buttons = 3'b000;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; wdat = 32'hFF;
    #2 rst = 1'b1;
    c = 0;
    repeat (3) begin @(posedge clk); #1; if (ack === 1'b1) c++; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    check("rst_mid_ack", 32'(c), 32'h0);
    model_reset();
    tick(1);
    check("rst2_leds", 32'(leds), 32'h0);
    check("rst2_led_enb", 32'(led_enb), 32'hFF);
    check("rst2_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 8; i++) rd_chk(i, "rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
